// File: rtl/fdtd_step_sequencer.sv
// FDTD time-step sequencer: runs Hy -> Ez -> Src engine handshakes for N steps.
// Optional stage watchdog compiled in with `define FDTD_STEP_WDOG_EN.
module fdtd_step_sequencer #(
    parameter int STEP_WIDTH = 16,
    parameter int WDOG_WIDTH = 16,
    parameter logic [WDOG_WIDTH-1:0] WDOG_LIMIT = {WDOG_WIDTH{1'b1}}
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic                  trigger_pulse_i,
    input  logic                  clr_int_pulse_i,
    input  logic                  int_en_i,
    input  logic [STEP_WIDTH-1:0] num_steps_i,
    output logic                  hy_start_o,
    output logic                  ez_start_o,
    output logic                  src_start_o,
    input  logic                  hy_done_i,
    input  logic                  ez_done_i,
    input  logic                  src_done_i,
    output logic                  hy_end_flg_o,
    output logic                  ez_end_flg_o,
    output logic                  src_end_flg_o,
    output logic                  busy_o,
    output logic                  int_pending_o,
    output logic                  irq_o,
    output logic [STEP_WIDTH-1:0] step_cnt_o,
    output logic                  timeout_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HY   = 2'd1;
    localparam logic [1:0] ST_EZ   = 2'd2;
    localparam logic [1:0] ST_SRC  = 2'd3;

    logic [1:0]            state_r, state_nxt_s;
    logic [STEP_WIDTH-1:0] n_r, n_nxt_s;
    logic [STEP_WIDTH-1:0] step_cnt_r, step_nxt_s, step_inc_s;
    logic                  hy_start_r, ez_start_r, src_start_r;
    logic                  hy_start_nxt_s, ez_start_nxt_s, src_start_nxt_s;
    logic                  hy_end_r, ez_end_r, src_end_r;
    logic                  hy_end_nxt_s, ez_end_nxt_s, src_end_nxt_s;
    logic                  busy_r;
    logic                  int_pending_r, int_nxt_s, set_int_s;
    logic                  done_acc_s;
    logic                  wdog_hit_s;

    assign step_inc_s = step_cnt_r + STEP_WIDTH'(1);

    // A done counts only from the engine owning the current state, after its start cycle.
    always_comb begin
        case (state_r)
            ST_HY:   done_acc_s = hy_done_i  & ~hy_start_r;
            ST_EZ:   done_acc_s = ez_done_i  & ~ez_start_r;
            ST_SRC:  done_acc_s = src_done_i & ~src_start_r;
            default: done_acc_s = 1'b0;
        endcase
    end

`ifdef FDTD_STEP_WDOG_EN
    logic [WDOG_WIDTH-1:0] wdog_r, wdog_nxt_s;
    logic                  timeout_r;

    assign wdog_hit_s = (state_r != ST_IDLE) && (wdog_r == WDOG_LIMIT) && !done_acc_s;

    // Watchdog restarts on every stage entry and counts while a stage runs.
    always_comb begin
        if (hy_start_nxt_s || ez_start_nxt_s || src_start_nxt_s) begin
            wdog_nxt_s = {WDOG_WIDTH{1'b0}};
        end else if (state_r != ST_IDLE) begin
            wdog_nxt_s = wdog_r + WDOG_WIDTH'(1);
        end else begin
            wdog_nxt_s = {WDOG_WIDTH{1'b0}};
        end
    end

    // Watchdog counter and sticky timeout flag; an abort beats a same-cycle clear.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wdog_r    <= {WDOG_WIDTH{1'b0}};
            timeout_r <= 1'b0;
        end else begin
            wdog_r <= wdog_nxt_s;
            if (wdog_hit_s) begin
                timeout_r <= 1'b1;
            end else if (clr_int_pulse_i || (state_r == ST_IDLE && trigger_pulse_i)) begin
                timeout_r <= 1'b0;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign timeout_o = timeout_r;
`else
    assign wdog_hit_s = 1'b0;
    assign timeout_o  = 1'b0;
`endif

    // Next-state, start-pulse, end-flag and step-count decisions.
    always_comb begin
        state_nxt_s     = state_r;
        n_nxt_s         = n_r;
        step_nxt_s      = step_cnt_r;
        hy_start_nxt_s  = 1'b0;
        ez_start_nxt_s  = 1'b0;
        src_start_nxt_s = 1'b0;
        hy_end_nxt_s    = hy_end_r;
        ez_end_nxt_s    = ez_end_r;
        src_end_nxt_s   = src_end_r;
        set_int_s       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (trigger_pulse_i) begin
                    n_nxt_s    = num_steps_i;
                    step_nxt_s = {STEP_WIDTH{1'b0}};
                    if (num_steps_i == {STEP_WIDTH{1'b0}}) begin
                        set_int_s = 1'b1;
                    end else begin
                        state_nxt_s    = ST_HY;
                        hy_start_nxt_s = 1'b1;
                        hy_end_nxt_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_HY: begin
                if (done_acc_s) begin
                    hy_end_nxt_s   = 1'b1;
                    state_nxt_s    = ST_EZ;
                    ez_start_nxt_s = 1'b1;
                    ez_end_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_HY;
                end
            end
            ST_EZ: begin
                if (done_acc_s) begin
                    ez_end_nxt_s    = 1'b1;
                    state_nxt_s     = ST_SRC;
                    src_start_nxt_s = 1'b1;
                    src_end_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = ST_EZ;
                end
            end
            ST_SRC: begin
                if (done_acc_s) begin
                    src_end_nxt_s = 1'b1;
                    step_nxt_s    = step_inc_s;
                    if (step_inc_s == n_r) begin
                        state_nxt_s = ST_IDLE;
                        set_int_s   = 1'b1;
                    end else begin
                        state_nxt_s    = ST_HY;
                        hy_start_nxt_s = 1'b1;
                        hy_end_nxt_s   = 1'b0;
                    end
                end else begin
                    state_nxt_s = ST_SRC;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
        if (wdog_hit_s) begin
            state_nxt_s   = ST_IDLE;
            hy_end_nxt_s  = 1'b1;
            ez_end_nxt_s  = 1'b1;
            src_end_nxt_s = 1'b1;
            set_int_s     = 1'b1;
        end else begin
            set_int_s = set_int_s;
        end
    end

    // Completion flag: any set event wins over a same-cycle clear.
    always_comb begin
        if (set_int_s) begin
            int_nxt_s = 1'b1;
        end else if (clr_int_pulse_i) begin
            int_nxt_s = 1'b0;
        end else begin
            int_nxt_s = int_pending_r;
        end
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_r       <= ST_IDLE;
            n_r           <= {STEP_WIDTH{1'b0}};
            step_cnt_r    <= {STEP_WIDTH{1'b0}};
            hy_start_r    <= 1'b0;
            ez_start_r    <= 1'b0;
            src_start_r   <= 1'b0;
            hy_end_r      <= 1'b1;
            ez_end_r      <= 1'b1;
            src_end_r     <= 1'b1;
            busy_r        <= 1'b0;
            int_pending_r <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            n_r           <= n_nxt_s;
            step_cnt_r    <= step_nxt_s;
            hy_start_r    <= hy_start_nxt_s;
            ez_start_r    <= ez_start_nxt_s;
            src_start_r   <= src_start_nxt_s;
            hy_end_r      <= hy_end_nxt_s;
            ez_end_r      <= ez_end_nxt_s;
            src_end_r     <= src_end_nxt_s;
            busy_r        <= (state_nxt_s != ST_IDLE);
            int_pending_r <= int_nxt_s;
        end
    end

    assign hy_start_o    = hy_start_r;
    assign ez_start_o    = ez_start_r;
    assign src_start_o   = src_start_r;
    assign hy_end_flg_o  = hy_end_r;
    assign ez_end_flg_o  = ez_end_r;
    assign src_end_flg_o = src_end_r;
    assign busy_o        = busy_r;
    assign int_pending_o = int_pending_r;
    assign irq_o         = int_pending_r & int_en_i;
    assign step_cnt_o    = step_cnt_r;

endmodule

// File: tb/tb_fdtd_step_sequencer.sv
// Directed bench for fdtd_step_sequencer: per-cycle vector table plus
// engine-responder sequences for multi-step runs, reset and watchdog cases.
module tb_fdtd_step_sequencer;

    logic        ACLK = 1'b0;
    logic        ARESETn = 1'b0;
    logic        trigger_pulse_i, clr_int_pulse_i, int_en_i;
    logic [15:0] num_steps_i;
    logic        hy_start_o, ez_start_o, src_start_o;
    logic        hy_done_i, ez_done_i, src_done_i;
    logic        hy_end_flg_o, ez_end_flg_o, src_end_flg_o;
    logic        busy_o, int_pending_o, irq_o, timeout_o;
    logic [15:0] step_cnt_o;

    int total = 0;
    int bad = 0;

    int seq[$];
    int nstart, run_cyc, last_done_cyc, irq_seen, ez_cnt, ez_cyc, stopped;

    typedef struct packed {
        logic        trig;
        logic        clr;
        logic        ie;
        logic [15:0] num;
        logic        hyd;
        logic        ezd;
        logic        srcd;
        logic [2:0]  st;
        logic [2:0]  ef;
        logic        busy;
        logic        intp;
        logic        irq;
        logic [15:0] step;
    } vec_t;

    vec_t tbl [13];

    fdtd_step_sequencer #(
        .STEP_WIDTH(16),
        .WDOG_WIDTH(16),
        .WDOG_LIMIT(16'd16)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .trigger_pulse_i(trigger_pulse_i),
        .clr_int_pulse_i(clr_int_pulse_i),
        .int_en_i(int_en_i),
        .num_steps_i(num_steps_i),
        .hy_start_o(hy_start_o),
        .ez_start_o(ez_start_o),
        .src_start_o(src_start_o),
        .hy_done_i(hy_done_i),
        .ez_done_i(ez_done_i),
        .src_done_i(src_done_i),
        .hy_end_flg_o(hy_end_flg_o),
        .ez_end_flg_o(ez_end_flg_o),
        .src_end_flg_o(src_end_flg_o),
        .busy_o(busy_o),
        .int_pending_o(int_pending_o),
        .irq_o(irq_o),
        .step_cnt_o(step_cnt_o),
        .timeout_o(timeout_o)
    );

    always #5 ACLK = ~ACLK;

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic clr_in();
        trigger_pulse_i = 1'b0;
        clr_int_pulse_i = 1'b0;
        num_steps_i     = 16'd0;
        hy_done_i       = 1'b0;
        ez_done_i       = 1'b0;
        src_done_i      = 1'b0;
    endtask

    // Engine model: answers each start pulse with its own done 'delay' cycles later.
    task automatic run_resp(input int delay, input int max_cyc, input bit wd_mode,
                            input bit trig_in_ez, input bit stop_src2);
        int cd;
        int eng;
        bit blk;
        cd = 0; eng = 0; blk = 1'b0;
        seq.delete();
        nstart = 0; run_cyc = -1; last_done_cyc = -1; irq_seen = 0;
        ez_cnt = 0; ez_cyc = -1; stopped = 0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (!busy_o) begin
                run_cyc = c;
                break;
            end
            clr_in();
            if (irq_o) irq_seen = 1;
            if (stop_src2 && src_start_o && step_cnt_o == 16'd1) begin
                stopped = 1;
                break;
            end
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    case (eng)
                        0: hy_done_i = 1'b1;
                        1: if (!blk) ez_done_i = 1'b1;
                        2: src_done_i = 1'b1;
                        default: ;
                    endcase
                    last_done_cyc = c;
                    if (trig_in_ez && eng == 1) begin
                        trigger_pulse_i = 1'b1;
                        num_steps_i     = 16'd7;
                        hy_done_i       = 1'b1;
                    end
                end
            end
            if (hy_start_o || ez_start_o || src_start_o) begin
                nstart++;
                eng = hy_start_o ? 0 : (ez_start_o ? 1 : 2);
                seq.push_back(eng);
                cd = delay;
                if (ez_start_o) begin
                    ez_cnt++;
                    if (wd_mode && ez_cnt == 2) begin
                        blk = 1'b1;
                        ez_cyc = c;
                    end
                end
            end
            tick();
        end
        clr_in();
        if (run_cyc < 0 && stopped == 0) begin
            total++;
            bad++;
            $display("FAIL run_bound: busy still %0d after %0d cycles", busy_o, max_cyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        //           trig  clr   ie    num     hyd   ezd   srcd  start   ends    busy  intp  irq   step
        tbl[0]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 16'd0};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 16'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'd1, 1'b0, 1'b0, 1'b0, 3'b100, 3'b011, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b011, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b101, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b101, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b0, 3'b001, 3'b110, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 16'd5, 1'b0, 1'b0, 1'b1, 3'b000, 3'b110, 1'b1, 1'b0, 1'b0, 16'd0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b111, 1'b0, 1'b1, 1'b1, 16'd1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 16'd1};
        tbl[12] = '{1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 16'd1};

        clr_in();
        int_en_i = 1'b1;
        ARESETn  = 1'b0;
        repeat (2) @(posedge ACLK);
        #3 ARESETn = 1'b1;

        for (int i = 0; i < 13; i++) begin
            trigger_pulse_i = tbl[i].trig;
            clr_int_pulse_i = tbl[i].clr;
            int_en_i        = tbl[i].ie;
            num_steps_i     = tbl[i].num;
            hy_done_i       = tbl[i].hyd;
            ez_done_i       = tbl[i].ezd;
            src_done_i      = tbl[i].srcd;
            tick();
            chk($sformatf("r%0d_start", i), {hy_start_o, ez_start_o, src_start_o}, tbl[i].st);
            chk($sformatf("r%0d_endflg", i), {hy_end_flg_o, ez_end_flg_o, src_end_flg_o}, tbl[i].ef);
            chk($sformatf("r%0d_busy", i), busy_o, tbl[i].busy);
            chk($sformatf("r%0d_intp", i), int_pending_o, tbl[i].intp);
            chk($sformatf("r%0d_irq", i), irq_o, tbl[i].irq);
            chk($sformatf("r%0d_step", i), step_cnt_o, tbl[i].step);
        end
        clr_in();

        // Three steps, engines answer two cycles after start.
        int_en_i = 1'b1;
        trigger_pulse_i = 1'b1;
        num_steps_i = 16'd3;
        tick();
        run_resp(2, 100, 1'b0, 1'b0, 1'b0);
        chk("n3_cycles", run_cyc, 28);
        chk("n3_intp_latency", run_cyc - last_done_cyc, 1);
        chk("n3_nstart", nstart, 9);
        for (int i = 0; i < 9; i++) chk($sformatf("n3_seq%0d", i), (i < seq.size()) ? seq[i] : -1, i % 3);
        chk("n3_step", step_cnt_o, 3);
        chk("n3_intp", int_pending_o, 1);
        chk("n3_irq", irq_o, 1);
        chk("n3_endflg", {hy_end_flg_o, ez_end_flg_o, src_end_flg_o}, 7);
        chk("timeout_idle", timeout_o, 0);
        clr_int_pulse_i = 1'b1;
        tick();
        clr_int_pulse_i = 1'b0;
        chk("clr_intp", int_pending_o, 0);

        // Trigger with N=7 and stray hy_done during EZ_RUN are ignored; irq masked.
        int_en_i = 1'b0;
        trigger_pulse_i = 1'b1;
        num_steps_i = 16'd2;
        tick();
        run_resp(1, 100, 1'b0, 1'b1, 1'b0);
        chk("ign_cycles", run_cyc, 13);
        chk("ign_nstart", nstart, 6);
        chk("ign_step", step_cnt_o, 2);
        chk("ign_intp", int_pending_o, 1);
        chk("ign_irq_seen", irq_seen, 0);
        chk("ign_irq", irq_o, 0);
        clr_int_pulse_i = 1'b1;
        tick();
        clr_int_pulse_i = 1'b0;

        // Asynchronous reset during step 2 SRC_RUN, then a clean one-step run.
        int_en_i = 1'b1;
        trigger_pulse_i = 1'b1;
        num_steps_i = 16'd3;
        tick();
        run_resp(2, 100, 1'b0, 1'b0, 1'b1);
        chk("rst_reached_src2", stopped, 1);
        #2 ARESETn = 1'b0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_start", {hy_start_o, ez_start_o, src_start_o}, 0);
        chk("rst_endflg", {hy_end_flg_o, ez_end_flg_o, src_end_flg_o}, 7);
        chk("rst_intp", int_pending_o, 0);
        chk("rst_step", step_cnt_o, 0);
        chk("rst_timeout", timeout_o, 0);
        #2 ARESETn = 1'b1;
        trigger_pulse_i = 1'b1;
        num_steps_i = 16'd1;
        tick();
        run_resp(1, 50, 1'b0, 1'b0, 1'b0);
        chk("post_cycles", run_cyc, 7);
        chk("post_nstart", nstart, 3);
        for (int i = 0; i < 3; i++) chk($sformatf("post_seq%0d", i), (i < seq.size()) ? seq[i] : -1, i);
        chk("post_step", step_cnt_o, 1);
        chk("post_intp", int_pending_o, 1);
        clr_int_pulse_i = 1'b1;
        tick();
        clr_int_pulse_i = 1'b0;

`ifdef FDTD_STEP_WDOG_EN
        // ez_done withheld in step 2: abort 17 cycles after ez_start.
        trigger_pulse_i = 1'b1;
        num_steps_i = 16'd2;
        tick();
        run_resp(1, 100, 1'b1, 1'b0, 1'b0);
        chk("wd_ez_cyc", ez_cyc, 9);
        chk("wd_abort_delay", run_cyc - ez_cyc, 17);
        chk("wd_step", step_cnt_o, 1);
        chk("wd_timeout", timeout_o, 1);
        chk("wd_intp", int_pending_o, 1);
        chk("wd_endflg", {hy_end_flg_o, ez_end_flg_o, src_end_flg_o}, 7);
        clr_int_pulse_i = 1'b1;
        tick();
        clr_int_pulse_i = 1'b0;
        chk("wd_clr_timeout", timeout_o, 0);
        chk("wd_clr_intp", int_pending_o, 0);
`else
        chk("timeout_tied", timeout_o, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
